// File: rtl/dual_wb_regfile.sv
// Dual-writeback register file: zero-latency reads with same-cycle write bypass, writes and busy scoreboard updated at posedge, no backpressure.
// Defining WB_CONFLICT_CNT_EN adds a saturating 16-bit counter of same-register slot conflicts on port conflictCount.
module dual_wb_regfile #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          wbEn1,
  input  logic [AW-1:0] wbReg1,
  input  logic [DW-1:0] wbData1,
  input  logic          wbEn2,
  input  logic [AW-1:0] wbReg2,
  input  logic [DW-1:0] wbData2,
  input  logic [AW-1:0] rdReg1A,
  input  logic [AW-1:0] rdReg1B,
  input  logic [AW-1:0] rdReg2A,
  input  logic [AW-1:0] rdReg2B,
  output logic [DW-1:0] rdData1A,
  output logic [DW-1:0] rdData1B,
  output logic [DW-1:0] rdData2A,
  output logic [DW-1:0] rdData2B,
  output logic          rdBusy1A,
  output logic          rdBusy1B,
  output logic          rdBusy2A,
  output logic          rdBusy2B,
  input  logic          issueEn1,
  input  logic [AW-1:0] issueReg1,
  input  logic          issueEn2,
  input  logic [AW-1:0] issueReg2
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [15:0]   conflictCount
`endif
);

  logic [DW-1:0]    regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  logic [AW-1:0]    rd_idx [4];
  logic [DW-1:0]    rd_dat [4];
  logic [3:0]       rd_bsy;

  // Clears first, then sets, so a newer producer issued this cycle keeps its busy bit.
  always_comb begin
    busy_nxt = busy;
    if (wbEn1)    busy_nxt[wbReg1]    = 1'b0;
    if (wbEn2)    busy_nxt[wbReg2]    = 1'b0;
    if (issueEn1) busy_nxt[issueReg1] = 1'b1;
    if (issueEn2) busy_nxt[issueReg2] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Slot 2 is the younger instruction, so its write is issued last and wins a conflict.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wbEn1 && (wbReg1 != '0)) regs[wbReg1] <= wbData1;
      if (wbEn2 && (wbReg2 != '0)) regs[wbReg2] <= wbData2;
    end
  end

  assign rd_idx[0] = rdReg1A;
  assign rd_idx[1] = rdReg1B;
  assign rd_idx[2] = rdReg2A;
  assign rd_idx[3] = rdReg2B;

  // Bypass priority mirrors write priority; a bypassing writeback also hides the stale busy bit.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rd_dat[p] = regs[rd_idx[p]];
      rd_bsy[p] = busy[rd_idx[p]];
      if (wbEn1 && (wbReg1 == rd_idx[p])) begin
        rd_dat[p] = wbData1;
        rd_bsy[p] = 1'b0;
      end
      if (wbEn2 && (wbReg2 == rd_idx[p])) begin
        rd_dat[p] = wbData2;
        rd_bsy[p] = 1'b0;
      end
      if ((rd_idx[p] == '0) || !RESET) begin
        rd_dat[p] = '0;
        rd_bsy[p] = 1'b0;
      end
    end
  end

  assign rdData1A = rd_dat[0];
  assign rdData1B = rd_dat[1];
  assign rdData2A = rd_dat[2];
  assign rdData2B = rd_dat[3];
  assign rdBusy1A = rd_bsy[0];
  assign rdBusy1B = rd_bsy[1];
  assign rdBusy2A = rd_bsy[2];
  assign rdBusy2B = rd_bsy[3];

`ifdef WB_CONFLICT_CNT_EN
  logic wb_conflict;

  assign wb_conflict = wbEn1 && wbEn2 && (wbReg1 == wbReg2) && (wbReg2 != '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      conflictCount <= '0;
    end else if (wb_conflict && (conflictCount != 16'hFFFF)) begin
      conflictCount <= conflictCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_wb_regfile.sv
// Directed self-checking bench for dual_wb_regfile; inputs change just after negedge, outputs sampled 1ns later.
module tb_dual_wb_regfile;

  logic        CLK;
  logic        RESET;
  logic        wbEn1, wbEn2;
  logic [4:0]  wbReg1, wbReg2;
  logic [31:0] wbData1, wbData2;
  logic [4:0]  rdReg1A, rdReg1B, rdReg2A, rdReg2B;
  logic [31:0] rdData1A, rdData1B, rdData2A, rdData2B;
  logic        rdBusy1A, rdBusy1B, rdBusy2A, rdBusy2B;
  logic        issueEn1, issueEn2;
  logic [4:0]  issueReg1, issueReg2;
`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] conflictCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dual_wb_regfile dut (
    .CLK(CLK), .RESET(RESET),
    .wbEn1(wbEn1), .wbReg1(wbReg1), .wbData1(wbData1),
    .wbEn2(wbEn2), .wbReg2(wbReg2), .wbData2(wbData2),
    .rdReg1A(rdReg1A), .rdReg1B(rdReg1B), .rdReg2A(rdReg2A), .rdReg2B(rdReg2B),
    .rdData1A(rdData1A), .rdData1B(rdData1B), .rdData2A(rdData2A), .rdData2B(rdData2B),
    .rdBusy1A(rdBusy1A), .rdBusy1B(rdBusy1B), .rdBusy2A(rdBusy2A), .rdBusy2B(rdBusy2B),
    .issueEn1(issueEn1), .issueReg1(issueReg1),
    .issueEn2(issueEn2), .issueReg2(issueReg2)
`ifdef WB_CONFLICT_CNT_EN
    , .conflictCount(conflictCount)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clear_in();
    wbEn1 = 1'b0; wbReg1 = '0; wbData1 = '0;
    wbEn2 = 1'b0; wbReg2 = '0; wbData2 = '0;
    issueEn1 = 1'b0; issueReg1 = '0;
    issueEn2 = 1'b0; issueReg2 = '0;
  endtask

  task automatic set_rd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d);
    rdReg1A = a; rdReg1B = b; rdReg2A = c; rdReg2B = d;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    clear_in();
    set_rd(0, 0, 0, 0);
    wbEn1 = 1'b1; wbReg1 = 5'd3; wbData1 = 32'hCAFEF00D;
    issueEn1 = 1'b1; issueReg1 = 5'd3;
    @(negedge CLK);
    for (int i = 0; i < 32; i++) begin
      set_rd(i[4:0], i[4:0], i[4:0], i[4:0]);
      #1;
      n_checks++; if (rdData1A !== 32'h0) begin n_fail++; $display("FAIL reset_data1A r%0d: got %h want 0", i, rdData1A); end
      n_checks++; if (rdData1B !== 32'h0) begin n_fail++; $display("FAIL reset_data1B r%0d: got %h want 0", i, rdData1B); end
      n_checks++; if (rdData2A !== 32'h0) begin n_fail++; $display("FAIL reset_data2A r%0d: got %h want 0", i, rdData2A); end
      n_checks++; if (rdData2B !== 32'h0) begin n_fail++; $display("FAIL reset_data2B r%0d: got %h want 0", i, rdData2B); end
      n_checks++; if ({rdBusy1A, rdBusy1B, rdBusy2A, rdBusy2B} !== 4'b0) begin
        n_fail++; $display("FAIL reset_busy r%0d: got %b want 0000", i, {rdBusy1A, rdBusy1B, rdBusy2A, rdBusy2B});
      end
    end
`ifdef WB_CONFLICT_CNT_EN
    n_checks++; if (conflictCount !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0", conflictCount); end
`endif
    @(negedge CLK);
    clear_in();
    RESET = 1'b1;
    wbEn1 = 1'b1; wbReg1 = 5'd0; wbData1 = 32'hDEADBEEF;
    set_rd(0, 3, 0, 3);
    #1;
    n_checks++; if (rdData1A !== 32'h0) begin n_fail++; $display("FAIL r0_bypass: got %h want 0", rdData1A); end
    n_checks++; if (rdData1B !== 32'h0) begin n_fail++; $display("FAIL r3_not_written_in_reset: got %h want 0", rdData1B); end
    n_checks++; if (rdBusy1B !== 1'b0) begin n_fail++; $display("FAIL r3_not_busy_after_reset: got %b want 0", rdBusy1B); end
    @(negedge CLK);
    clear_in();
    #1;
    n_checks++; if (rdData1A !== 32'h0) begin n_fail++; $display("FAIL r0_array: got %h want 0", rdData1A); end
  endtask

  task automatic test_bypass();
    @(negedge CLK);
    wbEn1 = 1'b1; wbReg1 = 5'd5; wbData1 = 32'h12345678;
    set_rd(5, 0, 0, 0);
    #1;
    n_checks++; if (rdData1A !== 32'h12345678) begin n_fail++; $display("FAIL bypass_r5: got %h want 12345678", rdData1A); end
    @(negedge CLK);
    clear_in();
    set_rd(5, 0, 0, 5);
    #1;
    n_checks++; if (rdData1A !== 32'h12345678) begin n_fail++; $display("FAIL array_r5_1A: got %h want 12345678", rdData1A); end
    n_checks++; if (rdData2B !== 32'h12345678) begin n_fail++; $display("FAIL array_r5_2B: got %h want 12345678", rdData2B); end
  endtask

  task automatic test_conflict();
    @(negedge CLK);
    wbEn1 = 1'b1; wbReg1 = 5'd7; wbData1 = 32'h1;
    wbEn2 = 1'b1; wbReg2 = 5'd7; wbData2 = 32'h2;
    set_rd(7, 5, 7, 7);
    #1;
    n_checks++; if (rdData1A !== 32'h2) begin n_fail++; $display("FAIL conflict_bypass_1A: got %h want 2", rdData1A); end
    n_checks++; if (rdData2B !== 32'h2) begin n_fail++; $display("FAIL conflict_bypass_2B: got %h want 2", rdData2B); end
    n_checks++; if (rdData1B !== 32'h12345678) begin n_fail++; $display("FAIL conflict_other_r5: got %h want 12345678", rdData1B); end
    @(negedge CLK);
    clear_in();
    #1;
    n_checks++; if (rdData2A !== 32'h2) begin n_fail++; $display("FAIL conflict_array: got %h want 2", rdData2A); end
`ifdef WB_CONFLICT_CNT_EN
    n_checks++; if (conflictCount !== 16'd1) begin n_fail++; $display("FAIL conflict_count: got %h want 1", conflictCount); end
`endif
  endtask

  task automatic test_scoreboard();
    @(negedge CLK);
    issueEn1 = 1'b1; issueReg1 = 5'd9;
    set_rd(9, 0, 0, 0);
    #1;
    n_checks++; if (rdBusy1A !== 1'b0) begin n_fail++; $display("FAIL issue_same_cycle_busy: got %b want 0", rdBusy1A); end
    @(negedge CLK);
    clear_in();
    #1;
    n_checks++; if (rdBusy1A !== 1'b1) begin n_fail++; $display("FAIL busy_cycle1: got %b want 1", rdBusy1A); end
    @(negedge CLK);
    #1;
    n_checks++; if (rdBusy1A !== 1'b1) begin n_fail++; $display("FAIL busy_cycle2: got %b want 1", rdBusy1A); end
    @(negedge CLK);
    wbEn2 = 1'b1; wbReg2 = 5'd9; wbData2 = 32'hA5A5A5A5;
    set_rd(9, 0, 9, 0);
    #1;
    n_checks++; if (rdBusy1A !== 1'b0) begin n_fail++; $display("FAIL wb_bypass_busy_1A: got %b want 0", rdBusy1A); end
    n_checks++; if (rdBusy2A !== 1'b0) begin n_fail++; $display("FAIL wb_bypass_busy_2A: got %b want 0", rdBusy2A); end
    n_checks++; if (rdData1A !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wb_bypass_data: got %h want a5a5a5a5", rdData1A); end
    @(negedge CLK);
    clear_in();
    #1;
    n_checks++; if (rdBusy1A !== 1'b0) begin n_fail++; $display("FAIL busy_cycle4: got %b want 0", rdBusy1A); end
    n_checks++; if (rdData1A !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL data_cycle4: got %h want a5a5a5a5", rdData1A); end
  endtask

  task automatic test_set_wins();
    @(negedge CLK);
    issueEn1 = 1'b1; issueReg1 = 5'd4;
    wbEn1 = 1'b1; wbReg1 = 5'd4; wbData1 = 32'h55;
    set_rd(4, 0, 0, 0);
    #1;
    n_checks++; if (rdData1A !== 32'h55) begin n_fail++; $display("FAIL setwin_bypass_data: got %h want 55", rdData1A); end
    @(negedge CLK);
    clear_in();
    #1;
    n_checks++; if (rdBusy1A !== 1'b1) begin n_fail++; $display("FAIL setwin_busy: got %b want 1", rdBusy1A); end
    n_checks++; if (rdData1A !== 32'h55) begin n_fail++; $display("FAIL setwin_data: got %h want 55", rdData1A); end
    // duplicate set on r11, writeback to non-busy r6, issue to r0 ignored
    @(negedge CLK);
    issueEn1 = 1'b1; issueReg1 = 5'd11;
    issueEn2 = 1'b1; issueReg2 = 5'd11;
    wbEn2 = 1'b1; wbReg2 = 5'd6; wbData2 = 32'h66;
    @(negedge CLK);
    clear_in();
    issueEn1 = 1'b1; issueReg1 = 5'd0;
    @(negedge CLK);
    clear_in();
    set_rd(11, 6, 4, 0);
    #1;
    n_checks++; if (rdBusy1A !== 1'b1) begin n_fail++; $display("FAIL dup_set_busy_r11: got %b want 1", rdBusy1A); end
    n_checks++; if (rdBusy1B !== 1'b0) begin n_fail++; $display("FAIL nonbusy_wb_busy_r6: got %b want 0", rdBusy1B); end
    n_checks++; if (rdData1B !== 32'h66) begin n_fail++; $display("FAIL nonbusy_wb_data_r6: got %h want 66", rdData1B); end
    n_checks++; if (rdBusy2A !== 1'b1) begin n_fail++; $display("FAIL still_busy_r4: got %b want 1", rdBusy2A); end
    n_checks++; if (rdBusy2B !== 1'b0) begin n_fail++; $display("FAIL r0_never_busy: got %b want 0", rdBusy2B); end
    // duplicate clear of r4 from both slots
    @(negedge CLK);
    wbEn1 = 1'b1; wbReg1 = 5'd4; wbData1 = 32'h44;
    wbEn2 = 1'b1; wbReg2 = 5'd4; wbData2 = 32'h88;
    @(negedge CLK);
    clear_in();
    #1;
    n_checks++; if (rdBusy2A !== 1'b0) begin n_fail++; $display("FAIL dup_clear_busy_r4: got %b want 0", rdBusy2A); end
    n_checks++; if (rdData2A !== 32'h88) begin n_fail++; $display("FAIL dup_clear_data_r4: got %h want 88", rdData2A); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    wbEn1 = 1'b1; wbReg1 = 5'd3; wbData1 = 32'hFF;
    @(negedge CLK);
    clear_in();
    set_rd(3, 11, 7, 0);
    #1;
    n_checks++; if (rdData1A !== 32'hFF) begin n_fail++; $display("FAIL pre_reset_r3: got %h want ff", rdData1A); end
    n_checks++; if (rdBusy1B !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy_r11: got %b want 1", rdBusy1B); end
    #2;
    wbEn1 = 1'b1; wbReg1 = 5'd3; wbData1 = 32'h77;
    RESET = 1'b0;
    #1;
    n_checks++; if (rdData1A !== 32'h0) begin n_fail++; $display("FAIL midreset_r3: got %h want 0", rdData1A); end
    n_checks++; if (rdBusy1B !== 1'b0) begin n_fail++; $display("FAIL midreset_busy_r11: got %b want 0", rdBusy1B); end
    n_checks++; if (rdData2A !== 32'h0) begin n_fail++; $display("FAIL midreset_r7: got %h want 0", rdData2A); end
    @(posedge CLK);
    #1;
    n_checks++; if (rdData1A !== 32'h0) begin n_fail++; $display("FAIL reset_drops_write: got %h want 0", rdData1A); end
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    n_checks++; if (rdData1A !== 32'h77) begin n_fail++; $display("FAIL post_reset_bypass: got %h want 77", rdData1A); end
    @(negedge CLK);
    clear_in();
    #1;
    n_checks++; if (rdData1A !== 32'h77) begin n_fail++; $display("FAIL first_write_after_reset: got %h want 77", rdData1A); end
`ifdef WB_CONFLICT_CNT_EN
    n_checks++; if (conflictCount !== 16'h0) begin n_fail++; $display("FAIL midreset_count: got %h want 0", conflictCount); end
`endif
  endtask

`ifdef WB_CONFLICT_CNT_EN
  task automatic test_saturate();
    @(negedge CLK);
    wbEn1 = 1'b1; wbReg1 = 5'd1; wbData1 = 32'h10;
    wbEn2 = 1'b1; wbReg2 = 5'd1; wbData2 = 32'h20;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (conflictCount !== 16'd3) begin n_fail++; $display("FAIL count_3: got %h want 3", conflictCount); end
    repeat (69997) @(posedge CLK);
    #1;
    n_checks++; if (conflictCount !== 16'hFFFF) begin n_fail++; $display("FAIL count_saturate: got %h want ffff", conflictCount); end
    @(negedge CLK);
    clear_in();
  endtask
`endif

  initial begin
    clear_in();
    set_rd(0, 0, 0, 0);
    RESET = 1'b0;
    test_reset();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_set_wins();
    test_reset_mid();
`ifdef WB_CONFLICT_CNT_EN
    test_saturate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_wb_regfile.md
Name: dual_wb_regfile

Overview:
- 32x32 architectural register file for the dual-issue pipeline. It is the receiving end of the two writeback pipe-register channels.
- Writes are committed on the clock edge. Four combinational read ports serve the two decode slots, with same-cycle write bypass.
- A busy-bit scoreboard is set by issue and cleared by writeback, so decode can stall on pending producers.

Parameters:
- NREGS, 32: number of architectural registers; must equal 2^AW.
- AW, 5: register index width.
- DW, 32: data width.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous reset, active-low
- wbEn1  in  1  writeback slot 1 valid
- wbReg1  in  AW  writeback slot 1 destination
- wbData1  in  DW  writeback slot 1 data
- wbEn2  in  1  writeback slot 2 valid (younger instruction)
- wbReg2  in  AW  writeback slot 2 destination
- wbData2  in  DW  writeback slot 2 data
- rdReg1A, rdReg1B, rdReg2A, rdReg2B  in  AW each  read indices (slot 1 rs/rt, slot 2 rs/rt)
- rdData1A, rdData1B, rdData2A, rdData2B  out  DW each  read data
- rdBusy1A, rdBusy1B, rdBusy2A, rdBusy2B  out  1 each  source has a pending producer
- issueEn1, issueEn2  in  1 each  instruction issued with a destination this cycle
- issueReg1, issueReg2  in  AW each  issued destinations
- conflictCount  out  16  present only with WB_CONFLICT_CNT_EN

Behaviour:
- Reset (RESET low, async):
  - All registers cleared to 0.
  - All busy bits cleared to 0.
  - conflictCount cleared to 0.
  - Consequently all rdData read 0 and all rdBusy read 0 while RESET is low.
- Write, at posedge CLK when RESET is high:
  - If wbEnN and wbRegN != 0, then reg[wbRegN] <= wbDataN.
  - Register 0 is never written and always reads 0.
- Write conflict (wbEn1 && wbEn2 && wbReg1 == wbReg2 != 0): slot 2 data is stored, because slot 2 is younger.
- Read (combinational, zero latency):
  - If rdReg == 0, data = 0.
  - Else if wbEn2 && wbReg2 == rdReg, data = wbData2.
  - Else if wbEn1 && wbReg1 == rdReg, data = wbData1.
  - Else data = reg[rdReg].
  - Net effect: write-before-read; a same-cycle writeback is visible to decode.
- Scoreboard, busy[NREGS], busy[0] hardwired to 0, updated at posedge CLK:
  - Clear: busy[wbRegN] <= 0 for each wbEnN.
  - Set: busy[issueRegN] <= 1 for each issueEnN with issueRegN != 0.
  - Set has priority over clear on the same index in the same cycle, because the newer producer wins.
  - Duplicate sets and duplicate clears are idempotent.
- rdBusyXY (combinational):
  - Equals busy[rdRegXY], masked to 0 when a same-cycle writeback to that index is bypassing.
  - Bypass clearing overrides any stored busy bit.
  - Same-cycle issue does not affect rdBusy until the next cycle; the intra-bundle dependency is handled by issue logic.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- Reset asserted mid-operation:
  - Immediate clear of all state; pending writes in that cycle are dropped.
  - Deassertion is synchronous in effect: the first write lands on the first posedge after RESET goes high.

Optional Feature:
- Macro: WB_CONFLICT_CNT_EN.
- Defined:
  - conflictCount port exists.
  - 16-bit counter increments at posedge on each write conflict (both enables set, same non-zero index).
  - Saturates at 16'hFFFF; reset to 0.
- Undefined:
  - Port and counter are absent.
  - Conflict resolution (slot 2 wins) is unchanged.

Test Plan:
- Reset then read all indices: every rdData = 0 and every rdBusy = 0. Write wbReg1=0, wbData1=32'hDEADBEEF, then read r0 -> 0.
- Cycle 1: wbEn1, r5 = 32'h12345678, with rdReg1A=5 in the same cycle -> rdData1A = 32'h12345678 (bypass). Next cycle, no write, read r5 -> 32'h12345678 (array).
- Both slots write r7, slot 1 = 32'h1, slot 2 = 32'h2:
  - Same-cycle read r7 -> 2; after the edge, read r7 -> 2.
  - With the macro defined, conflictCount = 1.
- issueEn1 r9 at cycle 0 -> rdBusy1A (r9) = 1 at cycle 1.
  - wbEn2 r9 = 32'hA5A5A5A5 at cycle 3 -> rdBusy1A = 0 and rdData1A = 32'hA5A5A5A5 in cycle 3.
  - Cycle 4: busy still 0.
- Same cycle: issueEn1 r4 and wbEn1 r4 = 32'h55 -> after the edge, busy[r4] = 1 (set wins) and reg r4 = 32'h55.
- Write r3 = 32'hFF, then assert RESET mid-cycle (async) -> rdData for r3 = 0 immediately. With the macro defined, 70000 consecutive conflicts -> conflictCount = 16'hFFFF.
